// File: rtl/input_event_arbiter_if.sv
// Event port between the input event arbiter and its consumer (valid/ready).
interface input_event_arbiter_if #(
   parameter int unsigned ID_W = 2
);
   logic            ev_valid;
   logic            ev_ready;
   logic [ID_W-1:0] ev_id;
   logic            ev_level;

   modport master (output ev_valid, output ev_id, output ev_level, input ev_ready);
   modport slave  (input ev_valid, input ev_id, input ev_level, output ev_ready);
endinterface

// File: rtl/input_event_arbiter.sv
// Input event arbiter: sample-tick prescaler for the filter bank, edge detect
// on the filtered inputs, pending-event latching and round-robin serialisation
// onto one valid/ready event port.
// Optional feature macro INPUT_EVENT_RELEASE_EN: when defined, falling edges
// are reported too (2N slots, slot 2i = rise, slot 2i+1 = fall of channel i).
module input_event_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned ID_W     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          in_stable_i,
   output logic                  sample_tick_o,
   output logic                  ev_overflow_o,
   input  logic                  ovf_clr_i,
   input_event_arbiter_if.master ev_if
);

`ifdef INPUT_EVENT_RELEASE_EN
   localparam int unsigned NS = 2 * N;
`else
   localparam int unsigned NS = N;
`endif
   localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic {IDLE, PRESENT} state_t;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            tick_q, tick_d;
   logic [N-1:0]    prev_q;
   logic [N-1:0]    rise;
`ifdef INPUT_EVENT_RELEASE_EN
   logic [N-1:0]    fall;
`endif
   logic [NS-1:0]   slot_ev;
   logic [NS-1:0]   pend_q, pend_d, clr_mask;
   logic [SW-1:0]   last_q, last_d, gnt_q, gnt_d, cand, gnt_sel;
   logic            found;
   state_t          state_q, state_d;
   logic            valid_q, valid_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            level_q, level_d;
   logic            ovf_q, ovf_d;

   // Free-running prescaler; tick fires the cycle after the count hits TICK_DIV-1
   always_comb begin
      tick_d = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
   end

   // Edge detection and mapping of edges onto arbitration slots
   always_comb begin
      slot_ev = '0;
      rise    = in_stable_i & ~prev_q;
`ifdef INPUT_EVENT_RELEASE_EN
      fall    = ~in_stable_i & prev_q;
      for (int i = 0; i < int'(N); i++) begin
         slot_ev[2*i]   = rise[i];
         slot_ev[2*i+1] = fall[i];
      end
`else
      slot_ev = rise;
`endif
   end

   // Arbiter FSM next state, grant selection, pending and overflow update
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      id_d     = id_q;
      level_d  = level_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      clr_mask = '0;
      found    = 1'b0;
      cand     = '0;
      gnt_sel  = '0;

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            // Round-robin search starting just after the last granted slot
            for (int k = 1; k <= int'(NS); k++) begin
               cand = SW'((int'(last_q) + k) % int'(NS));
               if (!found && pend_q[cand]) begin
                  found   = 1'b1;
                  gnt_sel = cand;
               end
            end
            if (found) begin
               clr_mask[gnt_sel] = 1'b1;
               gnt_d             = gnt_sel;
`ifdef INPUT_EVENT_RELEASE_EN
               id_d              = ID_W'(gnt_sel >> 1);
               level_d           = ~gnt_sel[0];
`else
               id_d              = ID_W'(gnt_sel);
               level_d           = 1'b1;
`endif
               valid_d           = 1'b1;
               state_d           = PRESENT;
            end
         end
         PRESENT: begin
            if (ev_if.ev_ready) begin
               valid_d = 1'b0;
               last_d  = gnt_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      // A new edge beats a same-cycle grant clear; an edge on a still-pending slot is lost
      pend_d = (pend_q & ~clr_mask) | slot_ev;
      ovf_d  = (|(slot_ev & pend_q & ~clr_mask)) | (ovf_q & ~ovf_clr_i);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         prev_q  <= '0;
         pend_q  <= '0;
         last_q  <= SW'(NS - 1);
         gnt_q   <= '0;
         state_q <= IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
         level_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         prev_q  <= in_stable_i;
         pend_q  <= pend_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         state_q <= state_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sample_tick_o  = tick_q;
   assign ev_overflow_o  = ovf_q;
   assign ev_if.ev_valid = valid_q;
   assign ev_if.ev_id    = id_q;
   assign ev_if.ev_level = level_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Scoreboard bench for input_event_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_input_event_arbiter;
   localparam int unsigned N        = 4;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned ID_W     = 2;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            level;
   } ev_t;

   logic         clk         = 1'b0;
   logic         rst         = 1'b1;
   logic [N-1:0] in_stable   = '0;
   logic         ovf_clr     = 1'b0;
   logic         sample_tick;
   logic         ev_overflow;

   int  errors  = 0;
   int  checks  = 0;
   ev_t expq[$];
   ev_t mon_e;
   bit  hs_prev = 1'b0;

   input_event_arbiter_if #(.ID_W(ID_W)) ev_if ();

   input_event_arbiter #(.N(N), .TICK_DIV(TICK_DIV), .ID_W(ID_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_stable_i   (in_stable),
      .sample_tick_o (sample_tick),
      .ev_overflow_o (ev_overflow),
      .ovf_clr_i     (ovf_clr),
      .ev_if         (ev_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int id, input bit lvl);
      ev_t e;
      e.id    = ID_W'(id);
      e.level = lvl;
      expq.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every accepted event against the scoreboard queue
   always @(negedge clk) begin
      if (rst) begin
         hs_prev <= 1'b0;
      end else begin
         if (hs_prev) chk("gap_after_handshake", 32'(ev_if.ev_valid), 32'd0);
         hs_prev <= ev_if.ev_valid & ev_if.ev_ready;
         if (ev_if.ev_valid && ev_if.ev_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got id=%0d level=%0b expected none at %0t",
                        ev_if.ev_id, ev_if.ev_level, $time);
            end else begin
               mon_e = expq.pop_front();
               chk("ev_id", 32'(ev_if.ev_id), 32'(mon_e.id));
               chk("ev_level", 32'(ev_if.ev_level), 32'(mon_e.level));
            end
         end
      end
   end

   initial begin
      ev_if.ev_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(ev_if.ev_valid), 32'd0);
      chk("rst_id", 32'(ev_if.ev_id), 32'd0);
      chk("rst_level", 32'(ev_if.ev_level), 32'd0);
      chk("rst_overflow", 32'(ev_overflow), 32'd0);
      chk("rst_tick", 32'(sample_tick), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Prescaler: tick one cycle wide at cycles 4, 8, 12 after release
      for (int k = 1; k <= 13; k++) begin
         step(1);
         chk("sample_tick", 32'(sample_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      end
      chk("idle_no_valid", 32'(ev_if.ev_valid), 32'd0);

      // All four channels rise together: served 0,1,2,3
      ev_if.ev_ready = 1'b1;
      in_stable = 4'b1111;
      push(0, 1); push(1, 1); push(2, 1); push(3, 1);
      step(1);
      chk("latency_e0_valid", 32'(ev_if.ev_valid), 32'd0);
      step(1);
      chk("latency_e1_valid", 32'(ev_if.ev_valid), 32'd1);
      chk("first_id", 32'(ev_if.ev_id), 32'd0);
      step(12);
      in_stable = 4'b0000;
`ifdef INPUT_EVENT_RELEASE_EN
      push(3, 0); push(0, 0); push(1, 0); push(2, 0);
`endif
      step(12);

      // Single rise on channel 0
      in_stable = 4'b0001;
      push(0, 1);
      step(1);
      chk("single_e0_valid", 32'(ev_if.ev_valid), 32'd0);
      step(1);
      chk("single_e1_valid", 32'(ev_if.ev_valid), 32'd1);
      chk("single_id", 32'(ev_if.ev_id), 32'd0);
      chk("single_level", 32'(ev_if.ev_level), 32'd1);
      step(1);
      chk("single_valid_drop", 32'(ev_if.ev_valid), 32'd0);
      step(6);
      in_stable = 4'b0000;
`ifdef INPUT_EVENT_RELEASE_EN
      push(0, 0);
`endif
      step(6);

      // Channels 0 and 2 rise after last grant on slot of channel 0: order 2,0
      in_stable = 4'b0101;
      push(2, 1); push(0, 1);
      step(2);
      chk("rr_first_id", 32'(ev_if.ev_id), 32'd2);
      step(8);
      in_stable = 4'b0000;
`ifdef INPUT_EVENT_RELEASE_EN
      push(0, 0); push(2, 0);
`endif
      step(8);

      // Overflow: channel 1 rises twice while channel 0 is held unaccepted
      ev_if.ev_ready = 1'b0;
      in_stable = 4'b0001;
      push(0, 1);
      step(4);
      chk("hold_valid", 32'(ev_if.ev_valid), 32'd1);
      chk("hold_id", 32'(ev_if.ev_id), 32'd0);
      in_stable = 4'b0011;
      push(1, 1);
      step(1);
      in_stable = 4'b0001;
`ifdef INPUT_EVENT_RELEASE_EN
      push(1, 0);
`endif
      step(1);
      chk("ovf_before", 32'(ev_overflow), 32'd0);
      in_stable = 4'b0011;
      step(1);
      chk("ovf_set", 32'(ev_overflow), 32'd1);
      chk("hold_id_after_ovf", 32'(ev_if.ev_id), 32'd0);
      ev_if.ev_ready = 1'b1;
      step(10);
      chk("ovf_sticky", 32'(ev_overflow), 32'd1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(ev_overflow), 32'd0);
      in_stable = 4'b0000;
`ifdef INPUT_EVENT_RELEASE_EN
      push(0, 0); push(1, 0);
`endif
      step(10);

      // Channel 2 pulse
      in_stable = 4'b0100;
      push(2, 1);
      step(5);
      in_stable = 4'b0000;
`ifdef INPUT_EVENT_RELEASE_EN
      push(2, 0);
`endif
      step(8);
      chk("queue_drained", 32'(expq.size()), 32'd0);

      // Asynchronous reset while an event is presented and overflow is set
      ev_if.ev_ready = 1'b0;
      in_stable = 4'b0001;
      step(3);
      chk("pre_rst_valid", 32'(ev_if.ev_valid), 32'd1);
      in_stable = 4'b0011;
      step(1);
      in_stable = 4'b0001;
      step(1);
      in_stable = 4'b0011;
      step(1);
      chk("pre_rst_ovf", 32'(ev_overflow), 32'd1);
      #2;
      rst = 1'b1;
      in_stable = 4'b0000;
      #1;
      chk("async_rst_valid", 32'(ev_if.ev_valid), 32'd0);
      chk("async_rst_ovf", 32'(ev_overflow), 32'd0);
      chk("async_rst_tick", 32'(sample_tick), 32'd0);
      ev_if.ev_ready = 1'b1;
      step(2);
      rst = 1'b0;
      step(12);
      chk("no_stale_valid", 32'(ev_if.ev_valid), 32'd0);
      chk("final_queue_empty", 32'(expq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/input_event_arbiter.md
Name: input_event_arbiter

Overview:
Controller for a bank of N input synchronizer/spike-filter channels.
- Generates the shared sample-enable tick for those channels.
- Detects edges on their stable outputs and latches each edge as a pending event.
- Serialises pending events onto one valid/ready event port using round-robin arbitration, for the downstream command/FSM logic.

Parameters:
N, 4, number of filtered input channels (1..16)
TICK_DIV, 1000, sample_tick period in clk cycles (>=2)
ID_W, $clog2(N) (min 1), width of ev_id

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_stable  in  N  stable outputs of the filter channels, already clk-synchronous
sample_tick  out  1  one-cycle enable for the filter channels
ev_valid  out  1  event available
ev_ready  in  1  consumer accepts event
ev_id  out  ID_W  channel index of the presented event
ev_level  out  1  1 = rising edge (press), 0 = falling edge (release)
ev_overflow  out  1  sticky: an event was lost
ovf_clr  in  1  clears ev_overflow

Behaviour:
- Reset: async, active-high. All state clears immediately, including mid-handshake. The presented event is discarded.
- Reset values: sample_tick=0, ev_valid=0, ev_id=0, ev_level=0, ev_overflow=0; prescaler=0, prev=0, all pending=0, last_grant=last slot.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - sample_tick is registered and high for exactly the one cycle after the count reaches TICK_DIV-1; period is TICK_DIV.
  - Free-running; not affected by arbitration.
- Edge detect:
  - prev <= in_stable every cycle.
  - rise[i] = in_stable[i] & ~prev[i]; fall[i] = ~in_stable[i] & prev[i].
- Slots:
  - Without the optional feature: N slots, slot i = rise of channel i.
  - With the feature: 2N slots, slot 2i = rise of channel i, slot 2i+1 = fall of channel i.
- Pending bits:
  - Each slot has one pending bit, set on its edge.
  - Set has priority over a grant-clear in the same cycle. The bit stays set and no overflow is raised.
  - Edge on a slot already pending and not cleared that cycle: the event is dropped and ev_overflow <= 1.
  - ovf_clr clears ev_overflow. A same-cycle overflow wins.
- FSM states: IDLE, PRESENT.
  - IDLE: if any pending bit is set, grant the first set slot searching from last_grant+1 with wrap-around.
    - Load ev_id = channel index and ev_level = edge type.
    - Clear that pending bit, set ev_valid=1, go to PRESENT.
    - If nothing is pending, stay in IDLE with ev_valid=0.
  - PRESENT: ev_valid, ev_id and ev_level are held stable until ev_valid & ev_ready.
    - On the handshake: ev_valid=0 next cycle, last_grant <= granted slot, go to IDLE.
- Latency: in_stable change before clk edge E0 -> pending set at E0 -> ev_valid high after E1 (2 cycles, idle arbiter).
- Throughput: at most 1 event per 2 cycles. Pending edges keep accumulating while in PRESENT.
- ev_ready is ignored while ev_valid=0.

Optional Feature:
INPUT_EVENT_RELEASE_EN
- Defined: falling edges generate events (ev_level=0); 2N slots, round-robin over 2N.
- Undefined: only rising edges are reported; falling edges are ignored; ev_level is constant 1 after the first grant (0 at reset); N slots.

Test Plan:
- TICK_DIV=4, release idle -> sample_tick pulses exactly at cycles 4, 8, 12 after reset release; single-cycle each.
- in_stable 0000->0001, ev_ready=1 -> ev_valid high 2 cycles later, ev_id=0, ev_level=1, one event only.
- in_stable 0000->1111 in one cycle, ev_ready=1 -> ids 0,1,2,3 in order, each valid one cycle with 1-cycle gaps. Repeat with 0000->0101 after last_grant=0 -> order 2,0.
- ev_ready=0 holding id 0; channel 1 rises, falls, rises again -> second rise sets ev_overflow=1; after ready, only one id=1 event. ovf_clr pulse -> ev_overflow=0.
- INPUT_EVENT_RELEASE_EN defined, channel 2 pulses 0->1->0 over 10 cycles -> events (id 2, level 1) then (id 2, level 0).
- rst asserted while ev_valid=1 mid-wait -> ev_valid/ev_overflow/sample_tick drop without a clk edge; after release no stale event is presented.
